ahb3lite_sdram_port_arb: RTL and testbench

- Round-robin arbiter that shares the single SDRAM command engine of ahb3lite_sdram_ctrl between AHB_PORTS AHB slave ports.
- Sits between the per-port AHB front-ends and the command sequencer.
- Issues one grant at a time and honours HMASTLOCK-style locked sequences.
- Gives auto-refresh priority, with a bounded deferral while a port holds a lock.

---
 rtl/ahb3lite_sdram_pkg.sv | 25 ++
 rtl/ahb3lite_sdram_port_arb_if.sv | 33 +++
 rtl/ahb3lite_sdram_rr_pick.sv | 41 ++++
 rtl/ahb3lite_sdram_port_arb.sv | 114 +++++++++++
 tb/tb_ahb3lite_sdram_port_arb.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb3lite_sdram_pkg.sv
// ahb3lite_sdram_pkg
// Types and helpers shared by the SDRAM controller, the port arbiter and
// the write-buffer flush arbiter.
//   arb_state_t : arbiter FSM encoding
//   onehot2bin  : one-hot (up to 8 bits) to binary index
package ahb3lite_sdram_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_REFRESH = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_PORTS = 8;

    function automatic logic [2:0] onehot2bin(input logic [ARB_MAX_PORTS-1:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 0; i < ARB_MAX_PORTS; i++) begin
            if (oh[i]) b = b | 3'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/ahb3lite_sdram_port_arb_if.sv
// ahb3lite_sdram_port_arb_if
// Request/grant bundle between the AHB port front-ends, the command
// sequencer and the port arbiter.
//   port_req_i / port_lock_i : per-port request and lock (levels)
//   xfer_done_i              : sequencer finished the granted access (pulse)
//   ref_req_i / ref_done_i   : refresh due (level) / refresh finished (pulse)
//   port_gnt_o, gnt_vld_o, gnt_id_o, ref_gnt_o : arbiter decisions
// slave  : arbiter side
// master : requester / sequencer side
interface ahb3lite_sdram_port_arb_if #(
    parameter int AHB_PORTS    = 1,
    parameter int PORT_ID_SIZE = $clog2(AHB_PORTS > 1 ? AHB_PORTS : 2)
);
    logic [AHB_PORTS-1:0]    port_req_i;
    logic [AHB_PORTS-1:0]    port_lock_i;
    logic                    xfer_done_i;
    logic                    ref_req_i;
    logic                    ref_done_i;
    logic [AHB_PORTS-1:0]    port_gnt_o;
    logic                    gnt_vld_o;
    logic [PORT_ID_SIZE-1:0] gnt_id_o;
    logic                    ref_gnt_o;

    modport slave (
        input  port_req_i, port_lock_i, xfer_done_i, ref_req_i, ref_done_i,
        output port_gnt_o, gnt_vld_o, gnt_id_o, ref_gnt_o
    );

    modport master (
        output port_req_i, port_lock_i, xfer_done_i, ref_req_i, ref_done_i,
        input  port_gnt_o, gnt_vld_o, gnt_id_o, ref_gnt_o
    );
endinterface

// File: rtl/ahb3lite_sdram_rr_pick.sv
// ahb3lite_sdram_rr_pick
// Combinational rotate-priority picker: the first set bit of req_i found
// searching upward from ptr_i+1 with wrap-around wins.
//   req_i    : request vector
//   ptr_i    : index of the previous winner
//   win_oh_o : one-hot winner (zero when no request)
//   win_id_o : binary index of the winner
module ahb3lite_sdram_rr_pick
    import ahb3lite_sdram_pkg::*;
#(
    parameter int N   = 1,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   win_oh_o,
    output logic [IDW-1:0] win_id_o
);

    logic [2:0] bin;

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        win_oh_o = '0;
        found    = 1'b0;
        idx      = '0;
        // i runs to N so the previous winner is considered last
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                win_oh_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign bin      = onehot2bin(ARB_MAX_PORTS'(win_oh_o));
    assign win_id_o = bin[IDW-1:0];

endmodule

// File: rtl/ahb3lite_sdram_port_arb.sv
// ahb3lite_sdram_port_arb
// Round-robin owner selection for the single SDRAM command engine, with
// locked sequences and refresh priority (bounded deferral under lock).
//   HCLK, HRESETn : clock, synchronous active-low reset
//   bus (slave)   : requests, locks, done pulses in; grants out
//
//   state       | meaning
//   ARB_IDLE    | nobody owns the engine; arbitrate next edge
//   ARB_GRANT   | one port owns the engine until its access completes
//   ARB_REFRESH | refresh sequence owns the engine until ref_done_i
module ahb3lite_sdram_port_arb
    import ahb3lite_sdram_pkg::*;
#(
    parameter int AHB_PORTS     = 1,
    parameter int REF_MAX_DEFER = 4,
    parameter int PORT_ID_SIZE  = $clog2(AHB_PORTS > 1 ? AHB_PORTS : 2)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    ahb3lite_sdram_port_arb_if.slave bus
);

    localparam int DW = $clog2(REF_MAX_DEFER + 1);
    localparam logic [DW-1:0] DEFER_MAX = DW'(REF_MAX_DEFER);
    localparam logic [PORT_ID_SIZE-1:0] PTR_RST = PORT_ID_SIZE'(AHB_PORTS - 1);

    arb_state_t              state_q;
    logic [AHB_PORTS-1:0]    port_gnt_q;
    logic [PORT_ID_SIZE-1:0] gnt_id_q;
    logic [PORT_ID_SIZE-1:0] ptr_q;
    logic                    ref_gnt_q;
    logic [DW-1:0]           defer_q;
    logic [DW-1:0]           defer_d;

    logic [AHB_PORTS-1:0]    pick_oh;
    logic [PORT_ID_SIZE-1:0] pick_id;
    logic                    owner_lock;
    logic                    force_ref;

    ahb3lite_sdram_rr_pick #(
        .N   (AHB_PORTS),
        .IDW (PORT_ID_SIZE)
    ) u_pick (
        .req_i    (bus.port_req_i),
        .ptr_i    (ptr_q),
        .win_oh_o (pick_oh),
        .win_id_o (pick_id)
    );

    assign owner_lock = |(port_gnt_q & bus.port_lock_i);
    assign defer_d    = (defer_q == DEFER_MAX) ? defer_q : defer_q + DW'(1);
    // Refresh is forced on the access that brings the deferral count to the limit
    assign force_ref  = bus.ref_req_i && (defer_d == DEFER_MAX);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ARB_IDLE;
            port_gnt_q <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= PTR_RST;
            ref_gnt_q  <= 1'b0;
            defer_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (bus.ref_req_i) begin
                        state_q   <= ARB_REFRESH;
                        ref_gnt_q <= 1'b1;
                        defer_q   <= '0;
                    end else if (|bus.port_req_i) begin
                        state_q    <= ARB_GRANT;
                        port_gnt_q <= pick_oh;
                        gnt_id_q   <= pick_id;
                        ptr_q      <= pick_id;
                    end
                end
                ARB_GRANT: begin
                    if (bus.xfer_done_i) begin
                        if (bus.ref_req_i) defer_q <= defer_d;
                        // Leaving through IDLE keeps a gap cycle before refresh takes over
                        if (force_ref || !owner_lock) begin
                            state_q    <= ARB_IDLE;
                            port_gnt_q <= '0;
                        end
                    end
                end
                ARB_REFRESH: begin
                    if (bus.ref_done_i) begin
                        state_q   <= ARB_IDLE;
                        ref_gnt_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ARB_IDLE;
                    port_gnt_q <= '0;
                    ref_gnt_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.port_gnt_o = port_gnt_q;
    assign bus.gnt_vld_o  = |port_gnt_q;
    assign bus.ref_gnt_o  = ref_gnt_q;

    generate
        if (AHB_PORTS == 1) begin : g_single
            assign bus.gnt_id_o = '0;
        end else begin : g_multi
            assign bus.gnt_id_o = gnt_id_q;
        end
    endgenerate

endmodule

// File: tb/tb_ahb3lite_sdram_port_arb.sv
module tb_ahb3lite_sdram_port_arb;

    logic HCLK = 1'b0;
    logic HRESETn;

    int compared = 0;
    int mismatched = 0;

    ahb3lite_sdram_port_arb_if #(.AHB_PORTS(3), .PORT_ID_SIZE(2)) bus ();

    ahb3lite_sdram_port_arb #(
        .AHB_PORTS     (3),
        .REF_MAX_DEFER (4),
        .PORT_ID_SIZE  (2)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.port_req_i  = '0;
        bus.port_lock_i = '0;
        bus.xfer_done_i = 1'b0;
        bus.ref_req_i   = 1'b0;
        bus.ref_done_i  = 1'b0;
        cyc(); cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b000) begin
            mismatched++; $display("FAIL reset_gnt: got %b expected 000", bus.port_gnt_o);
        end
        compared++;
        if (bus.gnt_vld_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_vld: got %b expected 0", bus.gnt_vld_o);
        end
        compared++;
        if (bus.gnt_id_o !== 2'd0) begin
            mismatched++; $display("FAIL reset_id: got %0d expected 0", bus.gnt_id_o);
        end
        compared++;
        if (bus.ref_gnt_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_ref: got %b expected 0", bus.ref_gnt_o);
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [1:0] exp_i [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        bus.port_req_i = 3'b111;
        for (int k = 0; k < 4; k++) begin
            cyc();
            compared++;
            if (bus.port_gnt_o !== exp_g[k] || bus.gnt_id_o !== exp_i[k]) begin
                mismatched++;
                $display("FAIL rr_grant[%0d]: got gnt=%b id=%0d expected gnt=%b id=%0d",
                         k, bus.port_gnt_o, bus.gnt_id_o, exp_g[k], exp_i[k]);
            end
            bus.xfer_done_i = 1'b1;
            cyc();
            bus.xfer_done_i = 1'b0;
            compared++;
            if (bus.port_gnt_o !== 3'b000 || bus.gnt_vld_o !== 1'b0 || bus.gnt_id_o !== exp_i[k]) begin
                mismatched++;
                $display("FAIL rr_idle_gap[%0d]: got gnt=%b vld=%b id=%0d expected gnt=000 vld=0 id=%0d",
                         k, bus.port_gnt_o, bus.gnt_vld_o, bus.gnt_id_o, exp_i[k]);
            end
        end
        bus.port_req_i = '0;
        cyc();
    endtask

    task automatic test_refresh_priority();
        bus.ref_req_i  = 1'b1;
        bus.port_req_i = 3'b010;
        cyc();
        compared++;
        if (bus.ref_gnt_o !== 1'b1 || bus.port_gnt_o !== 3'b000) begin
            mismatched++;
            $display("FAIL ref_prio: got ref=%b gnt=%b expected ref=1 gnt=000", bus.ref_gnt_o, bus.port_gnt_o);
        end
        bus.xfer_done_i = 1'b1;   // unrelated in REFRESH
        cyc();
        bus.xfer_done_i = 1'b0;
        compared++;
        if (bus.ref_gnt_o !== 1'b1 || bus.port_gnt_o !== 3'b000) begin
            mismatched++;
            $display("FAIL ref_ignore_done: got ref=%b gnt=%b expected ref=1 gnt=000", bus.ref_gnt_o, bus.port_gnt_o);
        end
        bus.ref_done_i = 1'b1;
        cyc();
        bus.ref_done_i = 1'b0;
        bus.ref_req_i  = 1'b0;
        compared++;
        if (bus.ref_gnt_o !== 1'b0 || bus.port_gnt_o !== 3'b000) begin
            mismatched++;
            $display("FAIL ref_exit_idle: got ref=%b gnt=%b expected ref=0 gnt=000", bus.ref_gnt_o, bus.port_gnt_o);
        end
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b010 || bus.gnt_id_o !== 2'd1) begin
            mismatched++;
            $display("FAIL ref_then_port1: got gnt=%b id=%0d expected gnt=010 id=1", bus.port_gnt_o, bus.gnt_id_o);
        end
        bus.port_req_i  = '0;
        bus.xfer_done_i = 1'b1;
        cyc();
        bus.xfer_done_i = 1'b0;
    endtask

    task automatic test_lock();
        bus.port_req_i  = 3'b100;
        bus.port_lock_i = 3'b100;
        cyc();
        for (int k = 0; k < 5; k++) begin
            bus.xfer_done_i = 1'b1;
            bus.ref_done_i  = (k == 2);   // unrelated in GRANT
            cyc();
            bus.xfer_done_i = 1'b0;
            bus.ref_done_i  = 1'b0;
            compared++;
            if (bus.port_gnt_o !== 3'b100 || bus.gnt_id_o !== 2'd2) begin
                mismatched++;
                $display("FAIL lock_hold[%0d]: got gnt=%b id=%0d expected gnt=100 id=2", k, bus.port_gnt_o, bus.gnt_id_o);
            end
            cyc();
        end
        bus.port_lock_i = '0;
        bus.port_req_i  = '0;
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b100) begin
            mismatched++;
            $display("FAIL lock_drop_no_done: got gnt=%b expected 100", bus.port_gnt_o);
        end
        bus.xfer_done_i = 1'b1;
        cyc();
        bus.xfer_done_i = 1'b0;
        compared++;
        if (bus.port_gnt_o !== 3'b000) begin
            mismatched++;
            $display("FAIL lock_release: got gnt=%b expected 000", bus.port_gnt_o);
        end
    endtask

    task automatic test_refresh_defer();
        bus.port_req_i  = 3'b110;
        bus.port_lock_i = 3'b010;
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b010) begin
            mismatched++;
            $display("FAIL defer_grant_p1: got gnt=%b expected 010", bus.port_gnt_o);
        end
        bus.ref_req_i = 1'b1;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            bus.xfer_done_i = 1'b1;
            cyc();
            bus.xfer_done_i = 1'b0;
            if (k < 4) begin
                compared++;
                if (bus.port_gnt_o !== 3'b010 || bus.ref_gnt_o !== 1'b0) begin
                    mismatched++;
                    $display("FAIL defer_hold[%0d]: got gnt=%b ref=%b expected gnt=010 ref=0",
                             k, bus.port_gnt_o, bus.ref_gnt_o);
                end
                cyc();
            end
        end
        compared++;
        if (bus.port_gnt_o !== 3'b000 || bus.ref_gnt_o !== 1'b0) begin
            mismatched++;
            $display("FAIL defer_revoke: got gnt=%b ref=%b expected gnt=000 ref=0", bus.port_gnt_o, bus.ref_gnt_o);
        end
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b000 || bus.ref_gnt_o !== 1'b1) begin
            mismatched++;
            $display("FAIL defer_refresh: got gnt=%b ref=%b expected gnt=000 ref=1", bus.port_gnt_o, bus.ref_gnt_o);
        end
        bus.ref_done_i  = 1'b1;
        bus.xfer_done_i = 1'b1;   // simultaneous; only ref_done_i applies
        cyc();
        bus.ref_done_i  = 1'b0;
        bus.xfer_done_i = 1'b0;
        bus.ref_req_i   = 1'b0;
        compared++;
        if (bus.ref_gnt_o !== 1'b0 || bus.port_gnt_o !== 3'b000) begin
            mismatched++;
            $display("FAIL defer_ref_exit: got ref=%b gnt=%b expected ref=0 gnt=000", bus.ref_gnt_o, bus.port_gnt_o);
        end
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b100 || bus.gnt_id_o !== 2'd2) begin
            mismatched++;
            $display("FAIL defer_rotate_p2: got gnt=%b id=%0d expected gnt=100 id=2", bus.port_gnt_o, bus.gnt_id_o);
        end
        bus.port_lock_i = '0;
        bus.port_req_i  = '0;
        bus.xfer_done_i = 1'b1;
        cyc();
        bus.xfer_done_i = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        bus.port_req_i = 3'b001;
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b001) begin
            mismatched++;
            $display("FAIL rst_pre_grant: got gnt=%b expected 001", bus.port_gnt_o);
        end
        HRESETn = 1'b0;
        cyc();
        HRESETn = 1'b1;
        bus.port_req_i = 3'b110;
        compared++;
        if (bus.port_gnt_o !== 3'b000 || bus.gnt_vld_o !== 1'b0 || bus.gnt_id_o !== 2'd0) begin
            mismatched++;
            $display("FAIL rst_mid_grant: got gnt=%b vld=%b id=%0d expected gnt=000 vld=0 id=0",
                     bus.port_gnt_o, bus.gnt_vld_o, bus.gnt_id_o);
        end
        cyc();
        compared++;
        if (bus.port_gnt_o !== 3'b010 || bus.gnt_id_o !== 2'd1) begin
            mismatched++;
            $display("FAIL rst_first_grant: got gnt=%b id=%0d expected gnt=010 id=1", bus.port_gnt_o, bus.gnt_id_o);
        end
        bus.port_req_i  = '0;
        bus.xfer_done_i = 1'b1;
        cyc();
        bus.xfer_done_i = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic [2:0] req;
        logic [2:0] g;
        int wait_c [3];
        req = '0;
        for (int i = 0; i < 3; i++) wait_c[i] = 0;
        bus.port_lock_i = '0;
        for (int c = 0; c < 10000; c++) begin
            cyc();
            g = bus.port_gnt_o;
            compared++;
            if ((g & (g - 3'd1)) !== 3'd0) begin
                mismatched++; $display("FAIL rnd_onehot@%0d: got gnt=%b expected one-hot or zero", c, g);
            end
            compared++;
            if (bus.ref_gnt_o === 1'b1 && g !== 3'd0) begin
                mismatched++; $display("FAIL rnd_gnt_in_ref@%0d: got gnt=%b expected 000", c, g);
            end
            compared++;
            if (bus.gnt_vld_o !== (|g)) begin
                mismatched++; $display("FAIL rnd_vld@%0d: got %b expected %b", c, bus.gnt_vld_o, |g);
            end
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !g[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] == 150) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rnd_starve@%0d: port %0d waited %0d cycles, expected under 150", c, i, wait_c[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (req[i] && g[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3, 0) == 0) req[i] = 1'b1;
                end
            end
            bus.port_req_i  = req;
            bus.xfer_done_i = (g != 3'd0) && ($urandom_range(2, 0) == 0);
            bus.ref_done_i  = 1'b0;
            if (bus.ref_gnt_o && $urandom_range(3, 0) == 0) begin
                bus.ref_done_i = 1'b1;
                bus.ref_req_i  = 1'b0;
            end else if (!bus.ref_req_i && $urandom_range(49, 0) == 0) begin
                bus.ref_req_i = 1'b1;
            end
        end
        bus.port_req_i  = '0;
        bus.xfer_done_i = 1'b0;
        bus.ref_done_i  = 1'b0;
        bus.ref_req_i   = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_refresh_priority();
        test_lock();
        test_refresh_defer();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
